// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite master bridge: response codes, FSM states
// and the data-width legality check.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_HALT
  } axil_state_e;

  function automatic bit data_w_ok(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite channel bundle; master modport faces the bridge, slave modport
// faces the interconnect.
interface axil_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import axil_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [2:0]        awprot;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  axil_resp_e        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [2:0]        arprot;
  logic [DATA_W-1:0] rdata;
  axil_resp_e        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_watchdog.sv
// Transaction watchdog: counts busy cycles and flags the terminal count.
// Only built with AXIL_TIMEOUT_EN defined.
`ifdef AXIL_TIMEOUT_EN
module axil_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired_c
);
  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = run && (cnt_q == CNT_W'(LIMIT - 1));

  // Cleared whenever the bridge is not busy, saturates at the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/axil_master_bridge.sv
// AXI4-Lite master bridging the core load/store handshake onto AXI channels.
// Optional watchdog enabled by defining AXIL_TIMEOUT_EN.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [2:0]  PROT        = 3'b000,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              axi_error,
  axil_master_bridge_if.master axi
);

  if (!data_w_ok(DATA_W) || (TIMEOUT_CYC < 2)) begin : g_bad_cfg
    $error("axil_master_bridge: DATA_W must be 32 or 64 and TIMEOUT_CYC >= 2");
  end

  axil_state_e       state_q, state_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, req_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_d, rsp_err_d, error_d;
  logic              timeout_c;

`ifdef AXIL_TIMEOUT_EN
  logic busy_c;
  assign busy_c = (state_q != ST_IDLE) && (state_q != ST_HALT);

  axil_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .run       (busy_c),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.awprot  = PROT;
  assign axi.arprot  = PROT;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Next-state and next-output logic; every AXI output is registered
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    error_d     = axi_error;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    req_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_we) begin
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        // AW and W complete independently, in any order
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axi.bvalid && bready_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = (axi.bresp == SLVERR) || (axi.bresp == DECERR);
        end
      end
      ST_RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi.rvalid && rready_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi.rdata;
          rsp_err_d   = (axi.rresp == SLVERR) || (axi.rresp == DECERR);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog expiry overrides whatever the channel logic decided
    if (timeout_c) begin
      state_d     = ST_HALT;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end

    error_d     = axi_error || (rsp_valid_d && rsp_err_d);
    bready_d    = (state_d == ST_WR_RESP);
    rready_d    = (state_d == ST_RD_DATA);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      axi_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= req_ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      axi_error <= error_d;
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed and randomised-backpressure bench for axil_master_bridge with a
// behavioural AXI4-Lite slave and a reference memory model.
module tb_axil_master_bridge;
  import axil_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err, axi_error;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_rdy = 0;

  always #5 clk = ~clk;

  axil_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axil_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .PROT(3'b000), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_error(axi_error), .axi(axi)
  );

  // Slave knobs
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit         ar_never = 1'b0;
  axil_resp_e b_resp_cfg = OKAY, r_resp_cfg = OKAY;
  bit         ovr_en = 1'b0;
  logic [31:0] ovr_addr = '0, ovr_data = '0;

  // Slave state
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, r_pend;
  logic [31:0] aw_addr_l, w_data_l, r_addr_l, s_rdata;
  logic [3:0]  w_strb_l;
  logic        s_bvalid, s_rvalid;
  axil_resp_e  s_bresp, s_rresp;
  logic [31:0] slv_mem [1024];
  bit          slv_wr  [1024];
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] cur_awaddr, cur_wdata, cur_araddr;
  logic [3:0]  cur_wstrb;

  function automatic logic [31:0] rd_default(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    if (ovr_en && (a == ovr_addr)) return ovr_data;
    if (slv_wr[a[11:2]]) return slv_mem[a[11:2]];
    return rd_default(a);
  endfunction

  assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
  assign axi.arready = axi.arvalid && !r_pend && !s_rvalid && !ar_never && (ar_cnt >= ar_dly);
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = s_bresp;
  assign axi.rvalid  = s_rvalid;
  assign axi.rresp   = s_rresp;
  assign axi.rdata   = s_rdata;

  assign aw_hs      = axi.awvalid && axi.awready;
  assign w_hs       = axi.wvalid && axi.wready;
  assign ar_hs      = axi.arvalid && axi.arready;
  assign cur_awaddr = aw_hs ? axi.awaddr : aw_addr_l;
  assign cur_wdata  = w_hs ? axi.wdata : w_data_l;
  assign cur_wstrb  = w_hs ? axi.wstrb : w_strb_l;
  assign cur_araddr = ar_hs ? axi.araddr : r_addr_l;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= OKAY; s_rresp <= OKAY;
      s_rdata <= '0; aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; r_addr_l <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= axi.awaddr; aw_cnt <= 0; end
      else if (axi.awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_data_l <= axi.wdata; w_strb_l <= axi.wstrb; w_cnt <= 0; end
      else if (axi.wvalid && !w_got) w_cnt <= w_cnt + 1;
      if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
      else if (!s_bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
        if (b_cnt >= b_dly) begin
          s_bvalid <= 1'b1; s_bresp <= b_resp_cfg; b_cnt <= 0;
          aw_got <= 1'b0; w_got <= 1'b0;
          slv_mem[cur_awaddr[11:2]] <= merge(slv_read(cur_awaddr), cur_wdata, cur_wstrb);
          slv_wr[cur_awaddr[11:2]]  <= 1'b1;
        end else b_cnt <= b_cnt + 1;
      end
      if (ar_hs) begin r_pend <= 1'b1; r_addr_l <= axi.araddr; ar_cnt <= 0; r_cnt <= 0; end
      else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
      if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
      else if (!s_rvalid && (r_pend || ar_hs)) begin
        if (r_cnt >= r_dly) begin
          s_rvalid <= 1'b1; s_rdata <= slv_read(cur_araddr); s_rresp <= r_resp_cfg;
          r_pend <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Protocol monitor: a valid waiting on ready must not drop
  logic aw_hold, w_hold, ar_hold;
  int   viol = 0;
  int   b_count = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      if ((aw_hold && !axi.awvalid) || (w_hold && !axi.wvalid) || (ar_hold && !axi.arvalid))
        viol <= viol + 1;
      aw_hold <= axi.awvalid && !axi.awready;
      w_hold  <= axi.wvalid && !axi.wready;
      ar_hold <= axi.arvalid && !axi.arready;
      if (axi.bvalid && axi.bready) b_count <= b_count + 1;
    end
  end

  logic [31:0] exp_mem [logic [31:0]];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return rd_default(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int g;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    check("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && req_ready) busy_rdy++;
    end while (!rsp_valid && lat < 60);
    check("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic reset_outs(input string tag);
    check(tag, 64'({req_ready, rsp_valid, rsp_err, axi_error, axi.awvalid, axi.wvalid,
                    axi.bready, axi.arvalid, axi.rready, rsp_rdata, axi.awaddr}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, b0, bad;
    logic [31:0] a, d, e;
    logic [3:0]  s;
    logic        we;

    repeat (2) @(negedge clk);
    reset_outs("reset_outputs");
    check("reset_prot", 64'({axi.awprot, axi.arprot}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Zero-wait load, latency and hold
    ovr_en = 1'b1; ovr_addr = 32'h1000; ovr_data = 32'hDEADBEEF;
    issue(1'b0, 32'h1000, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    check("t1_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    check("t1_pulse", 64'(rsp_valid), 64'd0);
    check("t1_hold", 64'(rsp_rdata), 64'hDEADBEEF);
    ovr_en = 1'b0;

    // Store with W accepted three cycles ahead of AW
    aw_dly = 3; b0 = b_count;
    issue(1'b1, 32'h2004, 32'h12345678, 4'b0011);
    @(negedge clk); check("t2_cyc1", 64'({axi.awvalid, axi.wvalid}), 64'b11);
    @(negedge clk); check("t2_cyc2", 64'({axi.awvalid, axi.wvalid}), 64'b10);
    @(negedge clk); check("t2_cyc3", 64'({axi.awvalid, axi.wvalid}), 64'b10);
    @(negedge clk); check("t2_cyc4", 64'({axi.awvalid, axi.wvalid}), 64'b10);
    @(negedge clk); check("t2_cyc5", 64'({axi.awvalid, axi.wvalid}), 64'b00);
    wait_rsp(lat);
    check("t2_err", 64'(rsp_err), 64'd0);
    check("t2_rdata_zero", 64'(rsp_rdata), 64'd0);
    repeat (3) @(negedge clk);
    check("t2_one_b", 64'(b_count - b0), 64'd1);
    aw_dly = 0;
    exp_mem[32'h2004] = 32'hC0DE5678;
    issue(1'b0, 32'h2004, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t2_readback", 64'(rsp_rdata), 64'hC0DE5678);
    check("t2_no_error", 64'(axi_error), 64'd0);

    // Random backpressure against the memory model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      issue(we, a, d, s);
      wait_rsp(lat);
      check("t4_err", 64'(rsp_err), 64'd0);
      if (we) begin
        exp_mem[a] = merge(model_read(a), d, s);
        check("t4_store_rdata", 64'(rsp_rdata), 64'd0);
      end else begin
        check("t4_load_rdata", 64'(rsp_rdata), 64'(model_read(a)));
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    check("t4_valid_drops", 64'(viol), 64'd0);
    check("t4_ready_while_busy", 64'(busy_rdy), 64'd0);

    // Error responses and the sticky flag
    r_resp_cfg = EXOKAY;
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t3_exokay_err", 64'(rsp_err), 64'd0);
    check("t3_exokay_sticky", 64'(axi_error), 64'd0);
    r_resp_cfg = SLVERR;
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t3_slverr_err", 64'(rsp_err), 64'd1);
    check("t3_slverr_sticky", 64'(axi_error), 64'd1);
    r_resp_cfg = OKAY;
    issue(1'b0, 32'h108, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t3_okay_err", 64'(rsp_err), 64'd0);
    check("t3_okay_data", 64'(rsp_rdata), 64'(model_read(32'h108)));
    check("t3_still_sticky", 64'(axi_error), 64'd1);
    b_resp_cfg = DECERR;
    issue(1'b1, 32'h10C, 32'h0BADF00D, 4'hF);
    wait_rsp(lat);
    exp_mem[32'h10C] = 32'h0BADF00D;
    check("t3_decerr_err", 64'(rsp_err), 64'd1);
    b_resp_cfg = OKAY;
    issue(1'b1, 32'h110, 32'h01020304, 4'hF);
    wait_rsp(lat);
    exp_mem[32'h110] = 32'h01020304;
    check("t3_store_okay_err", 64'(rsp_err), 64'd0);
    check("t3_store_sticky", 64'(axi_error), 64'd1);

    // Reset in the middle of WR_RESP
    b_dly = 6;
    issue(1'b1, 32'h120, 32'hA5A5A5A5, 4'hF);
    bad = 0;
    while (!axi.bready && bad < 20) begin @(negedge clk); bad++; end
    check("t6_in_wr_resp", 64'(axi.bready), 64'd1);
    rst = 1'b1;
    #1 reset_outs("t6_reset_outputs");
    @(negedge clk);
    rst = 1'b0; b_dly = 0;
    issue(1'b0, 32'h120, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t6_load_data", 64'(rsp_rdata), 64'(model_read(32'h120)));
    check("t6_load_err", 64'(rsp_err), 64'd0);
    check("t6_error_cleared", 64'(axi_error), 64'd0);

`ifdef AXIL_TIMEOUT_EN
    // Watchdog: AR never accepted
    ar_never = 1'b1;
    issue(1'b0, 32'h130, 32'h0, 4'h0);
    wait_rsp(lat);
    check("t5_timeout_cycle", 64'(lat), 64'(TMO + 1));
    check("t5_err", 64'(rsp_err), 64'd1);
    check("t5_sticky", 64'(axi_error), 64'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready || axi.arvalid || axi.awvalid || axi.wvalid) bad++;
    end
    check("t5_halted", 64'(bad), 64'd0);
    ar_never = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after_reset", 64'(req_ready), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
